// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Bridges the MEM pipeline stage to a data memory with a
//               busy-wait handshake. Checks access legality and alignment,
//               sizes store data, extends load results and abandons accesses
//               that stay busy for TIMEOUT wait cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
  parameter int TIMEOUT = 64
) (
  input  logic        CLK,
  input  logic        RESET,
  // CPU side
  input  logic        CPU_READ,
  input  logic        CPU_WRITE,
  input  logic [2:0]  CPU_FUNCT3,
  input  logic [31:0] CPU_ADDRESS,
  input  logic [31:0] CPU_WRITEDATA,
  output logic [31:0] CPU_READDATA,
  output logic        STALL,
  output logic        ERROR,
  // Memory side
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [2:0]  MEM_FUNCT3,
  output logic [31:0] MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT
);

  // Wait counter only has to reach TIMEOUT-1 (the last permitted wait cycle).
  localparam int                 c_cnt_w    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

  // Access-type encodings carried on the funct3 field.
  localparam logic [2:0] c_f3_b  = 3'b000;
  localparam logic [2:0] c_f3_h  = 3'b001;
  localparam logic [2:0] c_f3_w  = 3'b010;
  localparam logic [2:0] c_f3_bu = 3'b100;
  localparam logic [2:0] c_f3_hu = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [c_cnt_w-1:0]   r_wait_cnt;
  logic                 r_is_load;
  logic                 r_mem_read;
  logic                 r_mem_write;
  logic [2:0]           r_funct3;
  logic [31:0]          r_address;
  logic [31:0]          r_writedata;
  logic [31:0]          r_readdata;
  logic                 r_error;

  logic                 w_load_f3_ok;
  logic                 w_store_f3_ok;
  logic                 w_align_ok;
  logic                 w_one_req;
  logic                 w_legal;
  logic                 w_reject;
  logic                 w_accept;
  logic                 w_reject_now;
  logic                 w_complete;
  logic                 w_timeout;
  logic                 w_stall;
  logic [31:0]          w_store_data;
  logic [31:0]          w_load_data;

  // Decode which access types exist for loads/stores and their alignment rule.
  always_comb begin
    w_load_f3_ok  = 1'b0;
    w_store_f3_ok = 1'b0;
    w_align_ok    = 1'b1;
    case (CPU_FUNCT3)
      c_f3_b: begin
        w_load_f3_ok  = 1'b1;
        w_store_f3_ok = 1'b1;
      end
      c_f3_h: begin
        w_load_f3_ok  = 1'b1;
        w_store_f3_ok = 1'b1;
        w_align_ok    = ~CPU_ADDRESS[0];
      end
      c_f3_w: begin
        w_load_f3_ok  = 1'b1;
        w_store_f3_ok = 1'b1;
        w_align_ok    = (CPU_ADDRESS[1:0] == 2'b00);
      end
      c_f3_bu: begin
        w_load_f3_ok  = 1'b1;
      end
      c_f3_hu: begin
        w_load_f3_ok  = 1'b1;
        w_align_ok    = ~CPU_ADDRESS[0];
      end
      default: begin
        w_load_f3_ok  = 1'b0;
        w_store_f3_ok = 1'b0;
      end
    endcase
  end

  // A request is legal only when exactly one direction is asked for; asking
  // for both at once is treated the same as a malformed access.
  assign w_one_req    = CPU_READ ^ CPU_WRITE;
  assign w_legal      = w_one_req & (CPU_READ ? w_load_f3_ok : w_store_f3_ok) & w_align_ok;
  assign w_reject     = (CPU_READ | CPU_WRITE) & ~w_legal;

  assign w_accept     = (r_state == S_IDLE) & w_legal;
  assign w_reject_now = (r_state == S_IDLE) & w_reject;
  // Completion takes priority over timeout on the last permitted wait cycle.
  assign w_complete   = (r_state == S_WAIT) & ~MEM_BUSYWAIT;
  assign w_timeout    = (r_state == S_WAIT) & MEM_BUSYWAIT & (r_wait_cnt == c_cnt_last);

  // Store data sized to the access with unused upper bytes cleared.
  always_comb begin
    w_store_data = CPU_WRITEDATA;
    case (CPU_FUNCT3)
      c_f3_b:  w_store_data = {24'h000000, CPU_WRITEDATA[7:0]};
      c_f3_h:  w_store_data = {16'h0000, CPU_WRITEDATA[15:0]};
      default: w_store_data = CPU_WRITEDATA;
    endcase
  end

  // Load result extension selected by the latched access type.
  always_comb begin
    w_load_data = MEM_READDATA;
    case (r_funct3)
      c_f3_b:  w_load_data = {{24{MEM_READDATA[7]}}, MEM_READDATA[7:0]};
      c_f3_h:  w_load_data = {{16{MEM_READDATA[15]}}, MEM_READDATA[15:0]};
      c_f3_w:  w_load_data = MEM_READDATA;
      c_f3_bu: w_load_data = {24'h000000, MEM_READDATA[7:0]};
      c_f3_hu: w_load_data = {16'h0000, MEM_READDATA[15:0]};
      default: w_load_data = MEM_READDATA;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state selection and the combinational pipeline hold.
  always_comb begin
    w_next_state = r_state;
    w_stall      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_legal) begin
          w_next_state = S_REQ;
          w_stall      = 1'b1;
        end else if (w_reject) begin
          w_next_state = S_DONE;
        end
      end
      S_REQ: begin
        w_next_state = S_WAIT;
        w_stall      = 1'b1;
      end
      S_WAIT: begin
        w_stall = 1'b1;
        if (w_complete || w_timeout) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Capture the accepted request; these values stay stable through WAIT.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_address   <= 32'h0;
      r_funct3    <= 3'b000;
      r_writedata <= 32'h0;
      r_is_load   <= 1'b0;
    end else if (w_accept) begin
      r_address   <= CPU_ADDRESS;
      r_funct3    <= CPU_FUNCT3;
      r_writedata <= w_store_data;
      r_is_load   <= CPU_READ;
    end
  end

  // Memory strobes rise on acceptance and fall when WAIT ends either way.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end else if (w_accept) begin
      r_mem_read  <= CPU_READ;
      r_mem_write <= CPU_WRITE;
    end else if (w_complete || w_timeout) begin
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end
  end

  // Count busy wait cycles; restarted for every accepted access.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_wait_cnt <= '0;
    end else if (w_accept) begin
      r_wait_cnt <= '0;
    end else if ((r_state == S_WAIT) && MEM_BUSYWAIT && !w_timeout) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  // Load result register: updated by completed loads, cleared by any error.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_readdata <= 32'h0;
    end else if (w_reject_now || w_timeout) begin
      r_readdata <= 32'h0;
    end else if (w_complete && r_is_load) begin
      r_readdata <= w_load_data;
    end
  end

  // Error pulse, high for exactly the DONE cycle that follows a failure.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_error <= 1'b0;
    end else begin
      r_error <= w_reject_now | w_timeout;
    end
  end

  assign CPU_READDATA  = r_readdata;
  assign STALL         = w_stall;
  assign ERROR         = r_error;
  assign MEM_READ      = r_mem_read;
  assign MEM_WRITE     = r_mem_write;
  assign MEM_FUNCT3    = r_funct3;
  assign MEM_ADDRESS   = r_address;
  assign MEM_WRITEDATA = r_writedata;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Directed self-checking bench for mem_access_unit (TIMEOUT=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  logic        CLK;
  logic        RESET;
  logic        CPU_READ;
  logic        CPU_WRITE;
  logic [2:0]  CPU_FUNCT3;
  logic [31:0] CPU_ADDRESS;
  logic [31:0] CPU_WRITEDATA;
  logic [31:0] CPU_READDATA;
  logic        STALL;
  logic        ERROR;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [2:0]  MEM_FUNCT3;
  logic [31:0] MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;

  int errors = 0;
  int checks = 0;

  mem_access_unit #(.TIMEOUT(4)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .CPU_READ      (CPU_READ),
    .CPU_WRITE     (CPU_WRITE),
    .CPU_FUNCT3    (CPU_FUNCT3),
    .CPU_ADDRESS   (CPU_ADDRESS),
    .CPU_WRITEDATA (CPU_WRITEDATA),
    .CPU_READDATA  (CPU_READDATA),
    .STALL         (STALL),
    .ERROR         (ERROR),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_FUNCT3    (MEM_FUNCT3),
    .MEM_ADDRESS   (MEM_ADDRESS),
    .MEM_WRITEDATA (MEM_WRITEDATA),
    .MEM_READDATA  (MEM_READDATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT)
  );

  // 10 ns clock.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to 2 ns after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic clear_cpu();
    CPU_READ  = 1'b0;
    CPU_WRITE = 1'b0;
  endtask

  // Issue one legal access from IDLE; memory reports busy for nbusy wait
  // cycles. Returns in the DONE cycle.
  task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rword, input int nbusy);
    CPU_READ      = rd;
    CPU_WRITE     = wr;
    CPU_FUNCT3    = f3;
    CPU_ADDRESS   = addr;
    CPU_WRITEDATA = wdata;
    MEM_READDATA  = rword;
    MEM_BUSYWAIT  = (nbusy > 0);
    tick();                 // REQ
    clear_cpu();
    tick();                 // first WAIT cycle
    repeat (nbusy) tick();
    MEM_BUSYWAIT  = 1'b0;
    tick();                 // DONE
  endtask

  initial begin
    RESET         = 1'b1;
    CPU_READ      = 1'b0;
    CPU_WRITE     = 1'b0;
    CPU_FUNCT3    = 3'b000;
    CPU_ADDRESS   = 32'h0;
    CPU_WRITEDATA = 32'h0;
    MEM_READDATA  = 32'h0;
    MEM_BUSYWAIT  = 1'b0;

    // Reset values.
    #3;
    chk("rst_mem_read",  MEM_READ, 0);
    chk("rst_mem_write", MEM_WRITE, 0);
    chk("rst_mem_addr",  MEM_ADDRESS, 0);
    chk("rst_mem_f3",    MEM_FUNCT3, 0);
    chk("rst_mem_wdata", MEM_WRITEDATA, 0);
    chk("rst_rdata",     CPU_READDATA, 0);
    chk("rst_error",     ERROR, 0);
    chk("rst_stall",     STALL, 0);
    tick();
    tick();
    RESET = 1'b0;

    // LB 0x10, word 0x000000F0, busy for two wait cycles.
    CPU_READ     = 1'b1;
    CPU_FUNCT3   = 3'b000;
    CPU_ADDRESS  = 32'h10;
    MEM_READDATA = 32'h000000F0;
    MEM_BUSYWAIT = 1'b1;
    #1;
    chk("lb_idle_stall", STALL, 1);
    chk("lb_idle_rd",    MEM_READ, 0);
    tick();                                   // REQ
    chk("lb_req_rd",     MEM_READ, 1);
    chk("lb_req_wr",     MEM_WRITE, 0);
    chk("lb_req_addr",   MEM_ADDRESS, 32'h10);
    chk("lb_req_f3",     MEM_FUNCT3, 3'b000);
    chk("lb_req_stall",  STALL, 1);
    CPU_READ    = 1'b0;
    CPU_ADDRESS = 32'hFFFF_FF00;              // ignored outside IDLE
    tick();                                   // WAIT 1
    chk("lb_wait_rd",    MEM_READ, 1);
    chk("lb_wait_stall", STALL, 1);
    tick();                                   // WAIT 2
    chk("lb_wait_addr",  MEM_ADDRESS, 32'h10);
    MEM_BUSYWAIT = 1'b0;
    tick();                                   // DONE
    chk("lb_rdata",      CPU_READDATA, 32'hFFFF_FFF0);
    chk("lb_done_stall", STALL, 0);
    chk("lb_done_rd",    MEM_READ, 0);
    chk("lb_done_err",   ERROR, 0);

    // A request presented in DONE is not taken until IDLE.
    CPU_READ     = 1'b1;
    CPU_FUNCT3   = 3'b101;
    CPU_ADDRESS  = 32'h12;
    #1;
    chk("done_no_stall", STALL, 0);
    tick();                                   // IDLE
    chk("done_no_accept", MEM_READ, 0);
    chk("idle_stall",     STALL, 1);

    // LHU / LH on word 0x00008001.
    do_access(1'b1, 1'b0, 3'b101, 32'h12, 32'h0, 32'h0000_8001, 0);
    chk("lhu_rdata", CPU_READDATA, 32'h0000_8001);
    tick();
    do_access(1'b1, 1'b0, 3'b001, 32'h12, 32'h0, 32'h0000_8001, 1);
    chk("lh_rdata",  CPU_READDATA, 32'hFFFF_8001);
    tick();

    // SB 0x20 with 0x12345678.
    CPU_WRITE     = 1'b1;
    CPU_FUNCT3    = 3'b000;
    CPU_ADDRESS   = 32'h20;
    CPU_WRITEDATA = 32'h1234_5678;
    MEM_BUSYWAIT  = 1'b0;
    #1;
    chk("sb_idle_stall", STALL, 1);
    tick();                                   // REQ
    chk("sb_req_wr",    MEM_WRITE, 1);
    chk("sb_req_rd",    MEM_READ, 0);
    chk("sb_req_wdata", MEM_WRITEDATA, 32'h0000_0078);
    chk("sb_req_f3",    MEM_FUNCT3, 3'b000);
    chk("sb_req_addr",  MEM_ADDRESS, 32'h20);
    clear_cpu();
    tick();                                   // WAIT
    chk("sb_wait_wr",   MEM_WRITE, 1);
    tick();                                   // DONE
    chk("sb_done_wr",   MEM_WRITE, 0);
    chk("sb_rdata_kept", CPU_READDATA, 32'hFFFF_8001);
    tick();

    // Misaligned LW at 0x06.
    CPU_READ    = 1'b1;
    CPU_FUNCT3  = 3'b010;
    CPU_ADDRESS = 32'h06;
    #1;
    chk("lw_mis_stall", STALL, 0);
    tick();                                   // DONE
    chk("lw_mis_err",   ERROR, 1);
    chk("lw_mis_rdata", CPU_READDATA, 0);
    chk("lw_mis_rd",    MEM_READ, 0);
    chk("lw_mis_stall_done", STALL, 0);
    clear_cpu();
    tick();                                   // IDLE
    chk("lw_mis_err_end", ERROR, 0);

    // Load and store asserted together.
    CPU_READ    = 1'b1;
    CPU_WRITE   = 1'b1;
    CPU_FUNCT3  = 3'b010;
    CPU_ADDRESS = 32'h40;
    #1;
    chk("both_stall", STALL, 0);
    tick();
    chk("both_err", ERROR, 1);
    chk("both_wr",  MEM_WRITE, 0);
    clear_cpu();
    tick();

    // Store with a load-only access type.
    CPU_WRITE   = 1'b1;
    CPU_FUNCT3  = 3'b100;
    CPU_ADDRESS = 32'h44;
    #1;
    chk("sbu_stall", STALL, 0);
    tick();
    chk("sbu_err", ERROR, 1);
    clear_cpu();
    tick();

    // LW completing on the last permitted wait cycle.
    do_access(1'b1, 1'b0, 3'b010, 32'h08, 32'h0, 32'hCAFE_BABE, 3);
    chk("lw_last_rdata", CPU_READDATA, 32'hCAFE_BABE);
    chk("lw_last_err",   ERROR, 0);
    tick();

    // LBU zero-extends.
    do_access(1'b1, 1'b0, 3'b100, 32'h13, 32'h0, 32'h0000_00F0, 0);
    chk("lbu_rdata", CPU_READDATA, 32'h0000_00F0);
    tick();

    // LW with memory stuck busy: error after four wait cycles.
    CPU_READ     = 1'b1;
    CPU_FUNCT3   = 3'b010;
    CPU_ADDRESS  = 32'h0C;
    MEM_BUSYWAIT = 1'b1;
    tick();                                   // REQ
    clear_cpu();
    tick();                                   // WAIT 1
    tick();                                   // WAIT 2
    chk("to_w2_err", ERROR, 0);
    tick();                                   // WAIT 3
    tick();                                   // WAIT 4
    chk("to_w4_err",   ERROR, 0);
    chk("to_w4_rd",    MEM_READ, 1);
    chk("to_w4_stall", STALL, 1);
    tick();                                   // DONE
    chk("to_err",   ERROR, 1);
    chk("to_rdata", CPU_READDATA, 0);
    chk("to_rd",    MEM_READ, 0);
    chk("to_stall", STALL, 0);
    tick();                                   // IDLE
    chk("to_err_end", ERROR, 0);
    MEM_BUSYWAIT = 1'b0;

    do_access(1'b1, 1'b0, 3'b010, 32'h50, 32'h0, 32'h1357_9BDF, 1);
    chk("lw_rdata", CPU_READDATA, 32'h1357_9BDF);
    tick();

    // SW aborted by reset in its second wait cycle.
    CPU_WRITE     = 1'b1;
    CPU_FUNCT3    = 3'b010;
    CPU_ADDRESS   = 32'h30;
    CPU_WRITEDATA = 32'hDEAD_BEEF;
    MEM_BUSYWAIT  = 1'b1;
    tick();                                   // REQ
    chk("sw_req_wr",    MEM_WRITE, 1);
    chk("sw_req_wdata", MEM_WRITEDATA, 32'hDEAD_BEEF);
    chk("sw_req_f3",    MEM_FUNCT3, 3'b010);
    clear_cpu();
    tick();                                   // WAIT 1
    tick();                                   // WAIT 2
    chk("sw_wait_wr", MEM_WRITE, 1);
    RESET = 1'b1;
    #1;
    chk("abort_wr",    MEM_WRITE, 0);
    chk("abort_addr",  MEM_ADDRESS, 0);
    chk("abort_wdata", MEM_WRITEDATA, 0);
    chk("abort_rdata", CPU_READDATA, 0);
    chk("abort_stall", STALL, 0);
    chk("abort_err",   ERROR, 0);
    tick();
    RESET        = 1'b0;
    MEM_BUSYWAIT = 1'b0;
    tick();
    chk("post_rst_err", ERROR, 0);
    chk("post_rst_wr",  MEM_WRITE, 0);

    // Normal operation resumes.
    do_access(1'b1, 1'b0, 3'b000, 32'h51, 32'h0, 32'h0000_007F, 0);
    chk("post_rst_lb", CPU_READDATA, 32'h0000_007F);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT, default 64: the maximum number of WAIT cycles before the unit abandons an access.
REQ-002 CLK  input  1  clock; all state updates on the rising edge.
REQ-003 RESET  input  1  asynchronous, active-high reset.
REQ-004 CPU_READ  input  1  load request from the MEM stage.
REQ-005 CPU_WRITE  input  1  store request from the MEM stage.
REQ-006 CPU_FUNCT3  input  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 CPU_ADDRESS  input  32  byte address.
REQ-008 CPU_WRITEDATA  input  32  store data, right-aligned.
REQ-009 CPU_READDATA  output  32  extended load result.
REQ-010 STALL  output  1  pipeline hold.
REQ-011 ERROR  output  1  one-cycle pulse: the access was rejected or timed out.
REQ-012 MEM_READ  output  1  read strobe to data memory.
REQ-013 MEM_WRITE  output  1  write strobe to data memory.
REQ-014 MEM_FUNCT3  output  3  access size to data memory.
REQ-015 MEM_ADDRESS  output  32  byte address to data memory.
REQ-016 MEM_WRITEDATA  output  32  store data to data memory.
REQ-017 MEM_READDATA  input  32  memory word; byte at MEM_ADDRESS occupies bits [7:0].
REQ-018 MEM_BUSYWAIT  input  1  high while memory has not completed the access.

Function
REQ-019 The unit SHALL implement the states IDLE, REQ, WAIT and DONE.
REQ-020 IDLE SHALL accept a request at a posedge when exactly one of CPU_READ/CPU_WRITE is high and the request is legal; it SHALL then latch address, funct3 and data, and go to REQ.
REQ-021 Legal requests: loads with funct3 in {000,001,010,100,101}; stores with funct3 in {000,001,010}; H/HU with ADDRESS[0]=0; W with ADDRESS[1:0]=00.
REQ-022 An illegal request, or CPU_READ and CPU_WRITE both high, SHALL cause: no memory strobe, ERROR pulsed for one cycle, CPU_READDATA=0, and a transition to DONE.
REQ-023 REQ SHALL hold MEM_READ or MEM_WRITE high for one cycle and then go unconditionally to WAIT.
REQ-024 WAIT SHALL keep the strobe high; at the first posedge with MEM_BUSYWAIT=0 it SHALL capture the load result into CPU_READDATA and go to DONE.
REQ-025 WAIT SHALL count cycles; if MEM_BUSYWAIT is still high on the TIMEOUT-th WAIT cycle, the unit SHALL pulse ERROR, set CPU_READDATA=0, and go to DONE.
REQ-026 DONE SHALL drop the strobes, keep STALL low, and return to IDLE after one cycle; a new request is never accepted in DONE.
REQ-027 STALL SHALL be combinational: high in REQ and WAIT, and high in IDLE while a legal request is present; low otherwise.
REQ-028 MEM_READ and MEM_WRITE SHALL be registered; they are high only in REQ and WAIT, and never high together.
REQ-029 MEM_ADDRESS and MEM_FUNCT3 SHALL be the latched values and stable from REQ through WAIT.
REQ-030 MEM_WRITEDATA SHALL be the latched data with unused bytes zeroed: SB keeps [7:0], SH keeps [15:0], SW keeps all 32 bits.
REQ-031 Load extraction SHALL be: LB sign-extends [7:0]; LH sign-extends [15:0]; LW passes the word; LBU zero-extends [7:0]; LHU zero-extends [15:0].
REQ-032 CPU_READDATA SHALL hold its value until the next completed load, error or reset; stores SHALL not modify it.
REQ-033 Changes on the CPU_* inputs outside IDLE SHALL be ignored.

Reset
REQ-034 RESET high SHALL immediately force state=IDLE, clear the WAIT counter, and drive MEM_READ=0, MEM_WRITE=0, MEM_ADDRESS=0, MEM_FUNCT3=0, MEM_WRITEDATA=0, CPU_READDATA=0 and ERROR=0.
REQ-035 RESET asserted in REQ or WAIT SHALL abort the access with no completion or ERROR pulse; after release, STALL follows the IDLE rule.

Verification
REQ-036 LB at addr 0x10, memory word 0x000000F0, busywait low after 2 cycles -> one REQ cycle, then WAIT; CPU_READDATA=0xFFFFFFF0; STALL drops in DONE.
REQ-037 LHU at addr 0x12, memory word 0x0000_8001 -> CPU_READDATA=0x00008001; LH on the same word -> 0xFFFF8001.
REQ-038 SB at addr 0x20 with data 0x12345678 -> MEM_WRITE=1, MEM_WRITEDATA=0x00000078, MEM_FUNCT3=000; CPU_READDATA unchanged.
REQ-039 LW at addr 0x06 -> no strobe, ERROR pulses for one cycle, CPU_READDATA=0, STALL low throughout.
REQ-040 LW with MEM_BUSYWAIT stuck high, TIMEOUT=4 -> ERROR pulses after 4 WAIT cycles, then DONE, then IDLE.
REQ-041 RESET asserted in the second WAIT cycle of an SW -> strobes low immediately, state IDLE, no ERROR pulse.
